// File: rtl/cbus_pkg.sv
// rtl/cbus_pkg.sv - CBus request/response structures shared by the arbiter and its users.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - N-to-1 CBus arbiter; locks the upstream port to one requester until its final beat.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int RR_POLICY = 0,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic            clk,
  input  logic            reset,
  input  cbus_req_t       ireqs  [NUM_PORTS],
  output cbus_resp_t      iresps [NUM_PORTS],
  output cbus_req_t       oreq,
  input  cbus_resp_t      oresp,
  output logic [IW-1:0]   grant_idx,
  output logic            busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [IW-1:0]        sel;
  logic [IW-1:0]        last_grant;
  logic [NUM_PORTS-1:0] valid_vec;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        cand;
  logic                 found;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  // Round-robin scans last_grant+1 .. last_grant+NUM_PORTS with an explicit
  // modulo so a non-power-of-two port count never yields an out-of-range index.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (RR_POLICY != 0) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = IW'((int'(last_grant) + k) % NUM_PORTS);
        if (!found && valid_vec[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (valid_vec[i]) begin
          winner = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|valid_vec) begin
            sel   <= winner;
            state <= BUSY;
            if (RR_POLICY != 0) begin
              last_grant <= winner;
            end
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Request fields are forwarded live; the requester keeps them stable until ready && last.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      oreq        = ireqs[sel];
      iresps[sel] = oresp;
    end
  end

  assign busy      = (state == BUSY);
  assign grant_idx = sel;

  owner_holds_valid: assert property (@(posedge clk) disable iff (reset)
    (state == BUSY) |-> valid_vec[sel]);

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one upstream CBus port (toward the CBus-to-AXI converter) among NUM_PORTS CBus requesters, e.g. port 0 = data, port 1 = instruction.
- Selects a requester in one arbitration cycle and locks the bus to it until the final response beat (ready && last).
- Forwards that requester's request upstream and routes the upstream response back only to it.
- Sits between the core's memory-side ports and the single converter instance in the top level.

Parameters:
- NUM_PORTS, 2: number of requesters, 2..8.
- RR_POLICY, 0: 0 = fixed priority (lowest index wins); 1 = round-robin (search starts after last granted index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ireqs  in  cbus_req_t[NUM_PORTS]  requester requests; fields valid, is_write, size, addr, strobe, data, len.
- iresps  out  cbus_resp_t[NUM_PORTS]  per-requester responses; fields ready, last, data.
- oreq  out  cbus_req_t  upstream request.
- oresp  in  cbus_resp_t  upstream response.
- grant_idx  out  $clog2(NUM_PORTS)  index currently owning the bus; debug only.
- busy  out  1  high while in BUSY.

Behaviour:
- State machine: IDLE and BUSY. Registers: state, sel (owner index), last_grant (RR pointer).
- Reset, or reset asserted in any state including mid-burst:
  - state = IDLE, sel = 0, last_grant = NUM_PORTS-1.
  - Next cycle: oreq all-zero (valid = 0), every iresps entry all-zero, busy = 0, grant_idx = 0.
  - Any burst in progress is abandoned; the converter is reset in the same cycle.
- IDLE:
  - oreq is all-zero and all iresps are zero.
  - If any ireqs[i].valid is set: sel <= winner, state <= BUSY, last_grant <= winner (RR only).
  - Fixed-priority winner: lowest valid index.
  - Round-robin winner: first valid index scanning last_grant+1, last_grant+2, … with wrap modulo NUM_PORTS.
  - If no requester is valid, stay in IDLE.
  - Arbitration costs exactly one cycle: a request first seen in IDLE appears on oreq the following cycle.
- BUSY:
  - oreq = ireqs[sel] combinationally.
  - iresps[sel] = oresp; every other iresps[j] = all-zero, so non-owners never see ready.
  - busy = 1, grant_idx = sel.
  - On a cycle with oresp.ready && oresp.last: state <= IDLE. Next cycle is IDLE, so there is exactly one idle cycle between back-to-back transactions.
  - oresp.ready without last (burst beats) leaves the state unchanged.
- Requester contract: a requester holds valid and all request fields stable from assertion until it observes ready && last. The arbiter does not latch request fields; it forwards them live.
- Owner drops valid before last: protocol violation. The arbiter stays in BUSY, forwards valid = 0 and waits for last. A simulation assertion flags it.
- Simultaneous events:
  - A requester raising valid in the same cycle the owner completes is not considered until the following IDLE cycle.
  - A new request from the just-completed owner competes normally. Under RR it loses to any other valid requester.
- Width rules: sel and last_grant are $clog2(NUM_PORTS) bits. RR wrap uses explicit modulo, so non-power-of-two NUM_PORTS works and never selects an index >= NUM_PORTS.
- No combinational path from oresp to oreq; the only combinational path is ireqs/oresp through muxing to oreq/iresps.

Test Plan:
- Reset behaviour: hold reset 3 cycles with both requesters valid -> oreq.valid = 0, busy = 0, all iresps.ready = 0 throughout; first grant appears 2 cycles after reset deasserts.
- Fixed-priority conflict (RR_POLICY=0): ports 0 and 1 both valid in the same cycle (port 0 addr 0x8000_0000 len 0; port 1 addr 0xBFC0_0000 len 3) -> port 0 served first (1 beat). Then 1 IDLE cycle, then port 1 served for 4 beats. iresps[1].ready stays 0 during port 0's beat.
- Round-robin fairness (RR_POLICY=1, NUM_PORTS=3): all three ports continuously valid, single-beat responses -> grant sequence 0,1,2,0,1,2; each port gets exactly 2 grants in 12 cycles.
- Burst lock: port 1 4-beat read with ready on cycles 2,4,5,7 (last on 7), port 0 raising valid at cycle 3 -> grant_idx stays 1 until after cycle 7; port 0 granted in cycle 9. iresps[1].data matches oresp.data on each beat.
- Reset mid-burst: assert reset after beat 2 of a 4-beat burst -> next cycle oreq.valid = 0, state IDLE; after release, the pending requester is re-arbitrated from scratch.
- Back-to-back same requester: port 0 re-asserts a write (strobe 4'b0011, data 0x1234_5678) in the cycle after its last beat, with port 1 idle -> granted after exactly one IDLE cycle; oreq.strobe = 4'b0011 and oreq.data = 0x1234_5678 forwarded unchanged.
